alt_cnt_decoy: RTL and testbench

ALT_CNT_DECOY -- requirements
Module: alt_cnt_decoy

---
 rtl/alt_qkd_pkg.sv | 27 ++
 rtl/alt_sat_cnt.sv | 24 ++
 rtl/alt_cnt_decoy.sv | 166 ++++++++++++++++
 tb/tb_alt_cnt_decoy.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_qkd_pkg.sv
// Shared widths and encodings for the QKD post-processing blocks.
// Used by alt_cnt_decoy and alt_cal_s1.
package alt_qkd_pkg;

    localparam int NV_W_DEF = 21;
    localparam int NU_W_DEF = 25;
    localparam int NO_W_DEF = 21;

    typedef enum logic [1:0] {
        EVT_VAC = 2'b00,
        EVT_DEC = 2'b01,
        EVT_SIG = 2'b10,
        EVT_BAD = 2'b11
    } evt_t;

    typedef enum logic {
        CS_IDLE = 1'b0,
        CS_RUN  = 1'b1
    } cnt_state_t;

    typedef enum logic [1:0] {
        L_IDLE = 2'b00,
        L_PEND = 2'b01,
        L_FIRE = 2'b10
    } lch_state_t;

endpackage

// File: rtl/alt_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module alt_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/alt_cnt_decoy.sv
// Per-block vacuum/decoy/signal event counter with a single-entry
// snapshot that is launched to the downstream s1 calculator.
module alt_cnt_decoy
    import alt_qkd_pkg::*;
#(
    parameter int NV_W = NV_W_DEF,
    parameter int NU_W = NU_W_DEF,
    parameter int NO_W = NO_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_evt_vld,
    input  logic [1:0]      i_evt_type,
    input  logic            i_blk_end,
    input  logic            i_s1_busy,
    output logic [NV_W-1:0] o_nv,
    output logic [NU_W-1:0] o_nu,
    output logic [NO_W-1:0] o_no,
    output logic            o_start,
    output logic            o_ovf,
    output logic            o_bad_evt,
    output logic            o_blk_drop
);

    cnt_state_t cst, cst_nxt;
    lch_state_t lst, lst_nxt;

    logic run;
    logic blk_close;
    logic take;
    logic drop;
    logic clr;

    logic inc_v, inc_u, inc_o, evt_bad;
    logic sat_v, sat_u, sat_o;
    logic hit_ovf;
    logic live_ovf, live_bad;

    logic [NV_W-1:0] cnt_v, snap_v;
    logic [NU_W-1:0] cnt_u, snap_u;
    logic [NO_W-1:0] cnt_o, snap_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            cst <= CS_IDLE;
        end else begin
            cst <= cst_nxt;
        end
    end

    always_comb begin
        cst_nxt = cst;
        unique case (cst)
            CS_IDLE: if (i_en)  cst_nxt = CS_RUN;
            CS_RUN:  if (!i_en) cst_nxt = CS_IDLE;
            default: cst_nxt = CS_IDLE;
        endcase
    end

    always_comb begin
        run = (cst == CS_RUN);
    end

    assign blk_close = run & i_blk_end;
    assign take      = blk_close & (lst != L_PEND);
    assign drop      = blk_close & (lst == L_PEND);
    assign clr       = ~run | ~i_en | blk_close;

    assign inc_v   = run & i_evt_vld & (i_evt_type == EVT_VAC);
    assign inc_u   = run & i_evt_vld & (i_evt_type == EVT_DEC);
    assign inc_o   = run & i_evt_vld & (i_evt_type == EVT_SIG);
    assign evt_bad = run & i_evt_vld & (i_evt_type == EVT_BAD);

    assign hit_ovf = (inc_v & sat_v) | (inc_u & sat_u) | (inc_o & sat_o);

    alt_sat_cnt #(.W(NV_W)) u_cnt_v (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .inc   (inc_v),
        .cnt   (cnt_v),
        .sat   (sat_v)
    );

    alt_sat_cnt #(.W(NU_W)) u_cnt_u (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .inc   (inc_u),
        .cnt   (cnt_u),
        .sat   (sat_u)
    );

    alt_sat_cnt #(.W(NO_W)) u_cnt_o (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .inc   (inc_o),
        .cnt   (cnt_o),
        .sat   (sat_o)
    );

    // An event coincident with the block end belongs to the closing block.
    assign snap_v = (inc_v & ~sat_v) ? cnt_v + NV_W'(1) : cnt_v;
    assign snap_u = (inc_u & ~sat_u) ? cnt_u + NU_W'(1) : cnt_u;
    assign snap_o = (inc_o & ~sat_o) ? cnt_o + NO_W'(1) : cnt_o;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            live_ovf <= 1'b0;
            live_bad <= 1'b0;
        end else begin
            live_ovf <= live_ovf | hit_ovf;
            live_bad <= live_bad | evt_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_nv      <= '0;
            o_nu      <= '0;
            o_no      <= '0;
            o_ovf     <= 1'b0;
            o_bad_evt <= 1'b0;
        end else if (take) begin
            o_nv      <= snap_v;
            o_nu      <= snap_u;
            o_no      <= snap_o;
            o_ovf     <= live_ovf | hit_ovf;
            o_bad_evt <= live_bad | evt_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_blk_drop <= 1'b0;
        end else if (drop) begin
            o_blk_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lst <= L_IDLE;
        end else begin
            lst <= lst_nxt;
        end
    end

    // A snapshot taken during L_FIRE re-arms straight into L_PEND.
    always_comb begin
        lst_nxt = lst;
        unique case (lst)
            L_IDLE:  if (take) lst_nxt = L_PEND;
            L_PEND:  if (!i_s1_busy) lst_nxt = L_FIRE;
            L_FIRE:  lst_nxt = take ? L_PEND : L_IDLE;
            default: lst_nxt = L_IDLE;
        endcase
    end

    always_comb begin
        o_start = (lst == L_FIRE);
    end

endmodule

// File: tb/tb_alt_cnt_decoy.sv
// Directed bench for alt_cnt_decoy; a second instance with a
// 4-bit vacuum counter exercises saturation.
module tb_alt_cnt_decoy;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_evt_vld;
    logic [1:0]  i_evt_type;
    logic        i_blk_end;
    logic        i_s1_busy;

    logic [20:0] nv;
    logic [24:0] nu;
    logic [20:0] no;
    logic        start, ovf, bad, drop;

    logic [3:0]  nv4;
    logic [24:0] nu4;
    logic [20:0] no4;
    logic        start4, ovf4, bad4, drop4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alt_cnt_decoy dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_evt_vld  (i_evt_vld),
        .i_evt_type (i_evt_type),
        .i_blk_end  (i_blk_end),
        .i_s1_busy  (i_s1_busy),
        .o_nv       (nv),
        .o_nu       (nu),
        .o_no       (no),
        .o_start    (start),
        .o_ovf      (ovf),
        .o_bad_evt  (bad),
        .o_blk_drop (drop)
    );

    alt_cnt_decoy #(.NV_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_evt_vld  (i_evt_vld),
        .i_evt_type (i_evt_type),
        .i_blk_end  (i_blk_end),
        .i_s1_busy  (i_s1_busy),
        .o_nv       (nv4),
        .o_nu       (nu4),
        .o_no       (no4),
        .o_start    (start4),
        .o_ovf      (ovf4),
        .o_bad_evt  (bad4),
        .o_blk_drop (drop4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic events(input logic [1:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            i_evt_vld  = 1'b1;
            i_evt_type = t;
            tick();
        end
        i_evt_vld = 1'b0;
    endtask

    task automatic close_blk;
        i_blk_end = 1'b1;
        tick();
        i_blk_end = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_en = 1'b0;
        i_evt_vld = 1'b0;
        i_evt_type = 2'b00;
        i_blk_end = 1'b0;
        i_s1_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({nv, nu, no} !== '0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", nv, nu, no);
        end
        checks++;
        if ({start, ovf, bad, drop} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {start, ovf, bad, drop});
        end
    endtask

    task automatic test_idle_blk_end;
        int seen;
        seen = 0;
        i_en = 1'b0;
        events(2'b00, 2);
        close_blk();
        for (int i = 0; i < 4; i++) begin
            if (start) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || nv !== 21'd0) begin
            failures++;
            $display("FAIL idle_blk_end starts=%0d nv=%0d exp starts=0 nv=0", seen, nv);
        end
    endtask

    task automatic test_basic;
        i_en = 1'b1;
        tick();
        events(2'b00, 5);
        events(2'b01, 7);
        events(2'b10, 3);
        close_blk();
        checks++;
        if (start !== 1'b0) begin
            failures++;
            $display("FAIL basic_t1_start got=%b exp=0", start);
        end
        tick();
        checks++;
        if (start !== 1'b1) begin
            failures++;
            $display("FAIL basic_t2_start got=%b exp=1", start);
        end
        checks++;
        if (nv !== 21'd5 || nu !== 25'd7 || no !== 21'd3) begin
            failures++;
            $display("FAIL basic_counts got=%0d/%0d/%0d exp=5/7/3", nv, nu, no);
        end
        checks++;
        if ({ovf, bad, drop} !== 3'b000) begin
            failures++;
            $display("FAIL basic_flags got=%b exp=000", {ovf, bad, drop});
        end
        tick();
        checks++;
        if (start !== 1'b0 || nv !== 21'd5) begin
            failures++;
            $display("FAIL basic_after start=%b nv=%0d exp start=0 nv=5", start, nv);
        end
    endtask

    task automatic test_zero_gap;
        i_blk_end  = 1'b1;
        i_evt_vld  = 1'b1;
        i_evt_type = 2'b01;
        tick();
        i_blk_end = 1'b0;
        tick();
        i_evt_vld = 1'b0;
        checks++;
        if (start !== 1'b1 || {nv, nu, no} !== {21'd0, 25'd1, 21'd0}) begin
            failures++;
            $display("FAIL gap_first start=%b got=%0d/%0d/%0d exp=1 0/1/0",
                     start, nv, nu, no);
        end
        close_blk();
        tick();
        checks++;
        if (start !== 1'b1 || nu !== 25'd1 || drop !== 1'b0) begin
            failures++;
            $display("FAIL gap_second start=%b nu=%0d drop=%b exp=1 1 0",
                     start, nu, drop);
        end
        tick();
    endtask

    task automatic test_busy;
        int bad_cyc;
        bad_cyc = 0;
        i_s1_busy = 1'b1;
        events(2'b10, 2);
        close_blk();
        for (int i = 0; i < 20; i++) begin
            if (start !== 1'b0 || no !== 21'd2) bad_cyc++;
            tick();
        end
        checks++;
        if (bad_cyc !== 0) begin
            failures++;
            $display("FAIL busy_hold bad_cycles=%0d exp=0", bad_cyc);
        end
        i_s1_busy = 1'b0;
        checks++;
        if (start !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop_early got=%b exp=0", start);
        end
        tick();
        checks++;
        if (start !== 1'b1 || no !== 21'd2) begin
            failures++;
            $display("FAIL busy_release start=%b no=%0d exp=1 2", start, no);
        end
        tick();
    endtask

    task automatic test_ovf;
        events(2'b00, 17);
        close_blk();
        tick();
        checks++;
        if (start !== 1'b1 || start4 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_start got=%b%b exp=11", start, start4);
        end
        checks++;
        if (nv !== 21'd17 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wide nv=%0d ovf=%b exp=17 0", nv, ovf);
        end
        checks++;
        if (nv4 !== 4'd15 || ovf4 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_narrow nv=%0d ovf=%b exp=15 1", nv4, ovf4);
        end
        tick();
    endtask

    task automatic test_drop;
        int starts;
        logic [20:0] seen_nv;
        starts = 0;
        seen_nv = '0;
        i_s1_busy = 1'b1;
        events(2'b00, 3);
        close_blk();
        events(2'b00, 4);
        close_blk();
        checks++;
        if (drop !== 1'b1 || start !== 1'b0) begin
            failures++;
            $display("FAIL drop_flag drop=%b start=%b exp=1 0", drop, start);
        end
        tick();
        tick();
        i_s1_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start) begin
                starts++;
                seen_nv = nv;
            end
        end
        checks++;
        if (starts !== 1 || seen_nv !== 21'd3) begin
            failures++;
            $display("FAIL drop_launch starts=%0d nv=%0d exp=1 3", starts, seen_nv);
        end
    endtask

    task automatic test_en_fall_bad;
        i_s1_busy  = 1'b1;
        i_evt_vld  = 1'b1;
        i_evt_type = 2'b11;
        tick();
        i_evt_type = 2'b00;
        tick();
        i_evt_vld = 1'b0;
        close_blk();
        i_en = 1'b0;
        tick();
        tick();
        i_s1_busy = 1'b0;
        tick();
        checks++;
        if (start !== 1'b1 || nv !== 21'd1) begin
            failures++;
            $display("FAIL enfall_launch start=%b nv=%0d exp=1 1", start, nv);
        end
        checks++;
        if (bad !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL enfall_flags bad=%b ovf=%b exp=1 0", bad, ovf);
        end
        tick();
        events(2'b00, 3);
        i_en = 1'b1;
        tick();
        close_blk();
        tick();
        checks++;
        if (start !== 1'b1 || nv !== 21'd0 || bad !== 1'b0) begin
            failures++;
            $display("FAIL idle_events start=%b nv=%0d bad=%b exp=1 0 0",
                     start, nv, bad);
        end
        tick();
    endtask

    task automatic test_rst_pend;
        int seen;
        seen = 0;
        i_s1_busy = 1'b1;
        events(2'b10, 2);
        close_blk();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_s1_busy = 1'b0;
        checks++;
        if ({nv, nu, no, start, ovf, bad, drop} !== '0) begin
            failures++;
            $display("FAIL rst_outputs got=%0d/%0d/%0d flags=%b exp=0",
                     nv, nu, no, {start, ovf, bad, drop});
        end
        for (int i = 0; i < 5; i++) begin
            if (start) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_no_start starts=%0d exp=0", seen);
        end
        events(2'b01, 2);
        close_blk();
        tick();
        checks++;
        if (start !== 1'b1 || {nv, nu, no} !== {21'd0, 25'd2, 21'd0}) begin
            failures++;
            $display("FAIL rst_next_blk start=%b got=%0d/%0d/%0d exp=1 0/2/0",
                     start, nv, nu, no);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_blk_end();
        test_basic();
        test_zero_gap();
        test_busy();
        test_ovf();
        test_drop();
        test_en_fall_bad();
        test_rst_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
